load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/riscv_pkg.sv | 45 ++++
 rtl/lsu_align.sv | 70 +++++++
 rtl/load_store_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared load/store definitions: memory access modes, LSU states, fault codes.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   mem_mode_e    - access width/extension encoding shared with the decode controller
//   lsu_state_e   - load/store unit FSM states
//   fault_cause_e - fault_cause_o codes
//   mode_legal()  - 1 when a mode/direction pair names a real access
package riscv_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_mode_e;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'b00,
    LSU_REQ    = 2'b01,
    LSU_WAIT_R = 2'b10,
    LSU_DONE   = 2'b11
  } lsu_state_e;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_ILLEGAL  = 2'b10,
    FAULT_TIMEOUT  = 2'b11
  } fault_cause_e;

  // Unsigned variants only make sense for loads; stores have no extension.
  function automatic logic mode_legal(input logic [2:0] mode, input logic we);
    logic ok;
    case (mode)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = ~we;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables/data replication, load lane select and extension, access checks.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
//
// Ports:
//   mode, we, addr_lo   - access descriptor (width/extension, direction, low address bits)
//   wdata               - raw store data (rs2)
//   rdata               - raw bus read word
//   be, wdata_lane      - byte enables and lane-replicated store data
//   rdata_ext           - selected lane, sign- or zero-extended to 32 bits
//   illegal, misaligned - access check results
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  mode,
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        illegal,
  output logic        misaligned
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    case (addr_lo)
      2'd0:    rbyte = rdata[7:0];
      2'd1:    rbyte = rdata[15:8];
      2'd2:    rbyte = rdata[23:16];
      default: rbyte = rdata[31:24];
    endcase
    rhalf = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    illegal    = ~mode_legal(mode, we);
    misaligned = 1'b0;
    be         = 4'b0000;
    wdata_lane = wdata;
    rdata_ext  = 32'h0;
    case (mem_mode_e'(mode))
      MEM_B, MEM_BU: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        // mode[2] marks the unsigned variants
        rdata_ext  = mode[2] ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
      end
      MEM_H, MEM_HU: begin
        misaligned = addr_lo[0];
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = mode[2] ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
      end
      MEM_W: begin
        misaligned = (addr_lo != 2'b00);
        be         = 4'b1111;
        rdata_ext  = rdata;
      end
      default: begin
        be = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns decode load/store requests into single-beat bus accesses with fault detection.
// Latency: store 2 stall cycles, load 3 stall cycles minimum; DONE pulses done_o for one cycle.
// Backpressure: holds bus_valid/addr/be/we stable until bus_ready, waits for bus_rvalid; gives up after TIMEOUT_CYC cycles.
//
// Ports:
//   clk, rst_n                   - clock, asynchronous active-low reset
//   rd_en, wr_en, mem_mode       - request from decode (held while stall_o is high)
//   addr, wdata                  - effective address and store data
//   stall_o, done_o, rdata_o     - pipeline hold, completion pulse, extended load result
//   fault_o, fault_cause_o       - fault pulse and cause (01 misaligned, 10 illegal, 11 timeout)
//   bus_valid/we/addr/wdata/be   - request channel to memory bus
//   bus_ready, bus_rvalid, bus_rdata - bus request acceptance and read return
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [2:0]  mem_mode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        fault_o,
  output logic [1:0]  fault_cause_o,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [2:0]       mode_q, mode_d;
  logic             we_q, we_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;
  fault_cause_e     cause_q, cause_d;
  logic             bus_valid_q, bus_valid_d;
  logic             bus_we_q, bus_we_d;
  logic [3:0]       bus_be_q, bus_be_d;

  // The aligner looks at the live request while idle (to check and steer it
  // before acceptance) and at the latched copy once an access is in flight.
  logic        in_idle;
  logic [2:0]  sel_mode;
  logic        sel_we;
  logic [1:0]  sel_addr_lo;
  logic [31:0] sel_wdata;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_illegal;
  logic        al_misaligned;

  assign in_idle     = (state_q == LSU_IDLE);
  assign sel_mode    = in_idle ? mem_mode    : mode_q;
  assign sel_we      = in_idle ? wr_en       : we_q;
  assign sel_addr_lo = in_idle ? addr[1:0]   : addr_q[1:0];
  assign sel_wdata   = in_idle ? wdata       : wdata_q;

  lsu_align u_align (
    .mode       (sel_mode),
    .we         (sel_we),
    .addr_lo    (sel_addr_lo),
    .wdata      (sel_wdata),
    .rdata      (bus_rdata),
    .be         (al_be),
    .wdata_lane (al_wdata),
    .rdata_ext  (al_rdata),
    .illegal    (al_illegal),
    .misaligned (al_misaligned)
  );

  logic         req_any;
  logic         accept;
  logic         idle_fault;
  fault_cause_e idle_cause;
  logic         timeout;

  always_comb begin
    req_any    = rd_en | wr_en;
    idle_fault = in_idle & req_any & (al_illegal | al_misaligned);
    accept     = in_idle & req_any & ~(al_illegal | al_misaligned);
    // An unknown mode has no meaningful alignment, so illegal wins.
    idle_cause = al_illegal ? FAULT_ILLEGAL : FAULT_MISALIGN;
    timeout    = (cnt_q == CNT_LAST);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mode_d      = mode_q;
    we_d        = we_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    fault_d     = 1'b0;
    cause_d     = FAULT_NONE;
    bus_valid_d = 1'b0;
    bus_we_d    = 1'b0;
    bus_be_d    = 4'b0000;

    case (state_q)
      LSU_IDLE: begin
        if (accept) begin
          state_d     = LSU_REQ;
          cnt_d       = '0;
          addr_d      = addr;
          wdata_d     = wdata;
          mode_d      = mem_mode;
          we_d        = wr_en;   // store wins when both enables are high
          bus_valid_d = 1'b1;
          bus_we_d    = wr_en;
          bus_be_d    = al_be;
        end
      end

      LSU_REQ: begin
        if (bus_ready) begin
          if (we_q) begin
            state_d = LSU_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = LSU_WAIT_R;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end else if (timeout) begin
          state_d = LSU_DONE;
          done_d  = 1'b1;
          fault_d = 1'b1;
          cause_d = FAULT_TIMEOUT;
          rdata_d = 32'h0;
        end else begin
          cnt_d       = cnt_q + CNT_W'(1);
          bus_valid_d = 1'b1;
          bus_we_d    = bus_we_q;
          bus_be_d    = bus_be_q;
        end
      end

      LSU_WAIT_R: begin
        if (bus_rvalid) begin
          state_d = LSU_DONE;
          done_d  = 1'b1;
          rdata_d = al_rdata;
        end else if (timeout) begin
          state_d = LSU_DONE;
          done_d  = 1'b1;
          fault_d = 1'b1;
          cause_d = FAULT_TIMEOUT;
          rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        // DONE: one-cycle completion; requests are not looked at here.
        state_d = LSU_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LSU_IDLE;
      cnt_q       <= '0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      mode_q      <= 3'b000;
      we_q        <= 1'b0;
      rdata_q     <= 32'h0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      cause_q     <= FAULT_NONE;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_be_q    <= 4'b0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mode_q      <= mode_d;
      we_q        <= we_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      cause_q     <= cause_d;
      bus_valid_q <= bus_valid_d;
      bus_we_q    <= bus_we_d;
      bus_be_q    <= bus_be_d;
    end
  end

  // Stall rises combinationally on acceptance so the pipeline freezes in the
  // same cycle the request is seen; DONE releases it.
  assign stall_o       = accept | (state_q == LSU_REQ) | (state_q == LSU_WAIT_R);
  assign done_o        = done_q;
  assign rdata_o       = rdata_q;
  assign fault_o       = idle_fault | fault_q;
  assign fault_cause_o = idle_fault ? idle_cause : cause_q;
  assign bus_valid     = bus_valid_q;
  assign bus_we        = bus_we_q;
  assign bus_be        = bus_be_q;
  assign bus_addr      = {addr_q[31:2], 2'b00};
  assign bus_wdata     = al_wdata;

endmodule
